// File: rtl/des_entry_sequencer_if.sv
// DES core launch/result handshake.
// Master is the sequencer, slave is the DES datapath.
interface des_entry_sequencer_if;
    logic        des_start;
    logic        des_done;
    logic [63:0] des_result;

    modport master (
        output des_start,
        input  des_done,
        input  des_result
    );

    modport slave (
        input  des_start,
        output des_done,
        output des_result
    );
endinterface

// File: rtl/des_entry_sequencer.sv
// Operator key/plaintext entry and single DES run sequencer.
// Buttons are synchronised and edge detected; phase drives LCD text.
module des_entry_sequencer #(
    parameter int WORD_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DES_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] sw_in,
    input  logic              send_data,
    input  logic              change_state,
    input  logic              encr_go,
    des_entry_sequencer_if.master des,
    output logic [63:0]       key_out,
    output logic [63:0]       data_out,
    output logic [63:0]       result_out,
    output logic              result_valid,
    output logic [3:0]        phase,
    output logic [1:0]        word_idx,
    output logic              fault
);

    localparam int CW = $clog2(DES_TIMEOUT) + 1;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        KEY_ENTRY  = 4'd1,
        KEY_SHOW   = 4'd2,
        DATA_ENTRY = 4'd3,
        DATA_SHOW  = 4'd4,
        ARMED      = 4'd5,
        RUN        = 4'd6,
        DONE       = 4'd7,
        FAULT      = 4'd15
    } state_e;

    logic [SYNC_STAGES-1:0] send_sync_q;
    logic [SYNC_STAGES-1:0] chg_sync_q;
    logic [SYNC_STAGES-1:0] go_sync_q;
    logic send_prev_q, chg_prev_q, go_prev_q;
    logic send_press, chg_press, go_press;

    state_e      state_q, state_d;
    logic [63:0] key_q, key_d;
    logic [63:0] data_q, data_d;
    logic [63:0] result_q, result_d;
    logic        rvalid_q, rvalid_d;
    logic [1:0]  idx_q, idx_d;
    logic        fault_q, fault_d;
    logic        start_q, start_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Button synchronisers, preset to the released level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            send_sync_q <= '1;
            chg_sync_q  <= '1;
            go_sync_q   <= '0;
            send_prev_q <= 1'b1;
            chg_prev_q  <= 1'b1;
            go_prev_q   <= 1'b0;
        end else begin
            send_sync_q <= {send_sync_q[SYNC_STAGES-2:0], send_data};
            chg_sync_q  <= {chg_sync_q[SYNC_STAGES-2:0], change_state};
            go_sync_q   <= {go_sync_q[SYNC_STAGES-2:0], encr_go};
            send_prev_q <= send_sync_q[SYNC_STAGES-1];
            chg_prev_q  <= chg_sync_q[SYNC_STAGES-1];
            go_prev_q   <= go_sync_q[SYNC_STAGES-1];
        end
    end

    assign send_press = send_prev_q & ~send_sync_q[SYNC_STAGES-1];
    assign chg_press  = chg_prev_q & ~chg_sync_q[SYNC_STAGES-1];
    assign go_press   = ~go_prev_q & go_sync_q[SYNC_STAGES-1];

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            key_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
            rvalid_q <= 1'b0;
            idx_q    <= '0;
            fault_q  <= 1'b0;
            start_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            data_q   <= data_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
            idx_q    <= idx_d;
            fault_q  <= fault_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: entry capture, run launch, timeout and clear.
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        data_d   = data_q;
        result_d = result_q;
        rvalid_d = rvalid_q;
        idx_d    = idx_q;
        fault_d  = fault_q;
        start_d  = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = KEY_ENTRY;
                idx_d   = '0;
            end
            KEY_ENTRY: begin
                if (send_press) begin
                    case (idx_q)
                        2'd0: key_d[63:48] = sw_in;
                        2'd1: key_d[47:32] = sw_in;
                        2'd2: key_d[31:16] = sw_in;
                        default: key_d[15:0] = sw_in;
                    endcase
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = KEY_SHOW;
                end
            end
            KEY_SHOW: begin
                if (chg_press) state_d = DATA_ENTRY;
            end
            DATA_ENTRY: begin
                if (send_press) begin
                    case (idx_q)
                        2'd0: data_d[63:48] = sw_in;
                        2'd1: data_d[47:32] = sw_in;
                        2'd2: data_d[31:16] = sw_in;
                        default: data_d[15:0] = sw_in;
                    endcase
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = DATA_SHOW;
                end
            end
            DATA_SHOW: begin
                if (chg_press) state_d = ARMED;
            end
            ARMED: begin
                if (go_press) begin
                    state_d = RUN;
                    start_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (des.des_done) begin
                    result_d = des.des_result;
                    rvalid_d = 1'b1;
                    state_d  = DONE;
                end else if (cnt_q == CW'(DES_TIMEOUT - 1)) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (go_press) begin
                    state_d  = RUN;
                    start_d  = 1'b1;
                    cnt_d    = '0;
                    rvalid_d = 1'b0;
                end else if (chg_press) begin
                    state_d  = KEY_ENTRY;
                    key_d    = '0;
                    data_d   = '0;
                    result_d = '0;
                    rvalid_d = 1'b0;
                    idx_d    = '0;
                end
            end
            FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                state_d = FAULT;
                fault_d = 1'b1;
            end
        endcase
    end

    assign des.des_start  = start_q;
    assign key_out        = key_q;
    assign data_out       = data_q;
    assign result_out     = result_q;
    assign result_valid   = rvalid_q;
    assign phase          = state_q;
    assign word_idx       = idx_q;
    assign fault          = fault_q;

endmodule

// File: tb/tb_des_entry_sequencer.sv
// Directed testbench for des_entry_sequencer.
// Each scenario task drives stimulus and checks outputs inline.
module tb_des_entry_sequencer;

    localparam int TMO = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw_in;
    logic        send_data, change_state, encr_go;
    logic [63:0] key_out, data_out, result_out;
    logic        result_valid, fault;
    logic [3:0]  phase;
    logic [1:0]  word_idx;

    int n_chk  = 0;
    int n_fail = 0;
    int starts = 0;

    des_entry_sequencer_if des ();

    des_entry_sequencer #(
        .WORD_W(16),
        .SYNC_STAGES(2),
        .DES_TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_in(sw_in),
        .send_data(send_data),
        .change_state(change_state),
        .encr_go(encr_go),
        .des(des.master),
        .key_out(key_out),
        .data_out(data_out),
        .result_out(result_out),
        .result_valid(result_valid),
        .phase(phase),
        .word_idx(word_idx),
        .fault(fault)
    );

    always #5 clk = ~clk;

    // Count launch pulses seen by the DES core.
    always @(posedge clk) if (rst && des.des_start) starts++;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_send(input logic [15:0] w);
        sw_in = w;
        send_data = 1'b0;
        tick(6);
        send_data = 1'b1;
        tick(6);
    endtask

    task automatic press_chg();
        change_state = 1'b0;
        tick(6);
        change_state = 1'b1;
        tick(6);
    endtask

    task automatic press_go();
        encr_go = 1'b1;
        tick(6);
        encr_go = 1'b0;
        tick(6);
    endtask

    task automatic press_send_chg(input logic [15:0] w);
        sw_in = w;
        send_data = 1'b0;
        change_state = 1'b0;
        tick(6);
        send_data = 1'b1;
        change_state = 1'b1;
        tick(6);
    endtask

    task automatic press_go_chg();
        encr_go = 1'b1;
        change_state = 1'b0;
        tick(6);
        encr_go = 1'b0;
        change_state = 1'b1;
        tick(6);
    endtask

    task automatic pulse_done(input logic [63:0] v);
        des.des_result = v;
        des.des_done = 1'b1;
        tick(1);
        des.des_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        n_chk++;
        if ({key_out, data_out, result_out} !== 192'd0) begin
            n_fail++;
            $display("FAIL reset_buses: got %h %h %h want 0", key_out, data_out, result_out);
        end
        n_chk++;
        if ({result_valid, des.des_start, fault, phase, word_idx} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rv=%b st=%b f=%b ph=%0d idx=%0d want 0",
                     result_valid, des.des_start, fault, phase, word_idx);
        end
        rst = 1'b1;
        tick(1);
        n_chk++;
        if (phase !== 4'd1) begin
            n_fail++;
            $display("FAIL reset_to_key_entry: got %0d want 1", phase);
        end
    endtask

    task automatic test_key_entry();
        logic [15:0] w [4];
        logic [1:0]  e [4];
        w = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        e = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            press_send(w[i]);
            n_chk++;
            if (word_idx !== e[i]) begin
                n_fail++;
                $display("FAIL key_idx%0d: got %0d want %0d", i, word_idx, e[i]);
            end
        end
        n_chk++;
        if (key_out !== 64'h123456789ABCDEF0) begin
            n_fail++;
            $display("FAIL key_out: got %h want 123456789abcdef0", key_out);
        end
        n_chk++;
        if (phase !== 4'd2) begin
            n_fail++;
            $display("FAIL key_show_phase: got %0d want 2", phase);
        end
    endtask

    task automatic test_data_run();
        int s0;
        press_chg();
        n_chk++;
        if (phase !== 4'd3) begin
            n_fail++;
            $display("FAIL data_entry_phase: got %0d want 3", phase);
        end
        press_send(16'h0123);
        press_send(16'h4567);
        press_send(16'h89AB);
        press_send(16'hCDEF);
        n_chk++;
        if (data_out !== 64'h0123456789ABCDEF || phase !== 4'd4) begin
            n_fail++;
            $display("FAIL data_out: got %h ph=%0d want 0123456789abcdef ph=4", data_out, phase);
        end
        press_chg();
        n_chk++;
        if (phase !== 4'd5) begin
            n_fail++;
            $display("FAIL armed_phase: got %0d want 5", phase);
        end
        s0 = starts;
        press_go();
        n_chk++;
        if (starts - s0 !== 1 || phase !== 4'd6) begin
            n_fail++;
            $display("FAIL launch: got pulses=%0d ph=%0d want 1 ph=6", starts - s0, phase);
        end
        pulse_done(64'h85E813540F0AB405);
        n_chk++;
        if (result_out !== 64'h85E813540F0AB405 || result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL result: got %h rv=%b want 85e813540f0ab405 rv=1", result_out, result_valid);
        end
        n_chk++;
        if (phase !== 4'd7 || key_out !== 64'h123456789ABCDEF0) begin
            n_fail++;
            $display("FAIL done_state: got ph=%0d key=%h want 7", phase, key_out);
        end
    endtask

    task automatic test_done_go_chg();
        int s0;
        s0 = starts;
        press_go_chg();
        n_chk++;
        if (phase !== 4'd6 || starts - s0 !== 1 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL go_wins: got ph=%0d pulses=%0d rv=%b want ph=6 1 rv=0",
                     phase, starts - s0, result_valid);
        end
        pulse_done(64'hCAFEF00D12345678);
        n_chk++;
        if (phase !== 4'd7 || result_out !== 64'hCAFEF00D12345678) begin
            n_fail++;
            $display("FAIL rerun_done: got ph=%0d res=%h want 7 cafef00d12345678", phase, result_out);
        end
        press_chg();
        n_chk++;
        if (phase !== 4'd1 || {key_out, data_out, result_out} !== 192'd0 || result_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_clear: got ph=%0d key=%h data=%h res=%h rv=%b want 1 and zeros",
                     phase, key_out, data_out, result_out, result_valid);
        end
    endtask

    task automatic test_hold_send();
        sw_in = 16'hAAAA;
        send_data = 1'b0;
        tick(100);
        send_data = 1'b1;
        tick(6);
        n_chk++;
        if (word_idx !== 2'd1 || key_out !== 64'hAAAA000000000000) begin
            n_fail++;
            $display("FAIL hold_send: got idx=%0d key=%h want 1 aaaa000000000000", word_idx, key_out);
        end
    endtask

    task automatic test_send_chg_together();
        press_send_chg(16'hBBBB);
        press_send_chg(16'hCCCC);
        n_chk++;
        if (phase !== 4'd1 || word_idx !== 2'd3) begin
            n_fail++;
            $display("FAIL send_chg_mid: got ph=%0d idx=%0d want 1 3", phase, word_idx);
        end
        press_send_chg(16'hDDDD);
        n_chk++;
        if (phase !== 4'd2 || word_idx !== 2'd0 || key_out !== 64'hAAAABBBBCCCCDDDD) begin
            n_fail++;
            $display("FAIL send_chg_last: got ph=%0d idx=%0d key=%h want 2 0 aaaabbbbccccdddd",
                     phase, word_idx, key_out);
        end
    endtask

    task automatic test_reset_mid_run();
        press_chg();
        press_send(16'h1111);
        press_send(16'h2222);
        press_send(16'h3333);
        press_send(16'h4444);
        press_chg();
        press_go();
        n_chk++;
        if (phase !== 4'd6) begin
            n_fail++;
            $display("FAIL mid_run_setup: got %0d want 6", phase);
        end
        rst = 1'b0;
        #1;
        n_chk++;
        if ({key_out, data_out, result_out} !== 192'd0 ||
            {result_valid, des.des_start, fault, phase, word_idx} !== 9'd0) begin
            n_fail++;
            $display("FAIL async_abort: got key=%h data=%h ph=%0d want zeros", key_out, data_out, phase);
        end
        tick(2);
        rst = 1'b1;
        tick(1);
        n_chk++;
        if (phase !== 4'd1) begin
            n_fail++;
            $display("FAIL post_reset_phase: got %0d want 1", phase);
        end
        pulse_done(64'hFFFFFFFFFFFFFFFF);
        tick(2);
        n_chk++;
        if (phase !== 4'd1 || result_valid !== 1'b0 || result_out !== 64'd0) begin
            n_fail++;
            $display("FAIL stray_done: got ph=%0d rv=%b res=%h want 1 0 0", phase, result_valid, result_out);
        end
    endtask

    task automatic test_timeout();
        int s, f, s0;
        press_send(16'hA1A1);
        press_send(16'hB2B2);
        press_send(16'hC3C3);
        press_send(16'hD4D4);
        press_chg();
        press_send(16'h0001);
        press_send(16'h0002);
        press_send(16'h0003);
        press_send(16'h0004);
        press_chg();
        s = -1;
        f = -1;
        s0 = starts;
        encr_go = 1'b1;
        for (int c = 0; c < TMO + 200 && f < 0; c++) begin
            tick(1);
            if (c == 6) encr_go = 1'b0;
            if (des.des_start === 1'b1 && s < 0) s = c;
            if (phase === 4'hF) f = c;
        end
        encr_go = 1'b0;
        n_chk++;
        if (f < 0 || s < 0 || f - s !== TMO) begin
            n_fail++;
            $display("FAIL timeout_cycles: got start=%0d fault_at=%0d want gap %0d", s, f, TMO);
        end
        n_chk++;
        if (fault !== 1'b1 || phase !== 4'hF) begin
            n_fail++;
            $display("FAIL fault_flag: got f=%b ph=%0d want 1 15", fault, phase);
        end
        pulse_done(64'h0123012301230123);
        press_go();
        press_chg();
        press_send(16'h9999);
        n_chk++;
        if (phase !== 4'hF || fault !== 1'b1 || result_valid !== 1'b0 || starts - s0 !== 1) begin
            n_fail++;
            $display("FAIL fault_terminal: got ph=%0d f=%b rv=%b pulses=%0d want 15 1 0 1",
                     phase, fault, result_valid, starts - s0);
        end
    endtask

    initial begin
        rst = 1'b0;
        sw_in = 16'd0;
        send_data = 1'b1;
        change_state = 1'b1;
        encr_go = 1'b0;
        des.des_done = 1'b0;
        des.des_result = 64'd0;
        #1;
        test_reset();
        test_key_entry();
        test_data_run();
        test_done_go_chg();
        test_hold_send();
        test_send_chg_together();
        test_reset_mid_run();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
